// File: rtl/pulse_train_generator.sv
// Programmable pulse train generator: emits N pulses of H active / L inactive cycles
// and pushes a timestamped 128-bit report on completion, abort or restart.
module pulse_train_generator #(
  parameter int DATA_WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   cmd_in,
  input  logic          valid,
  input  logic [63:0]   counter,
  output logic          pulse_out,
  output logic          busy,
  output logic          write,
  output logic [127:0]  report_out
);

  localparam int W = DATA_WIDTH;

  localparam logic [3:0] OP_START     = 4'd1;
  localparam logic [3:0] OP_STOP      = 4'd2;
  localparam logic [3:0] OP_SET_IDLE  = 4'd3;
  localparam logic [3:0] ST_DONE      = 4'd1;
  localparam logic [3:0] ST_ABORTED   = 4'd2;
  localparam logic [3:0] ST_RESTARTED = 4'd3;

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t         state, next_state;
  logic [W-1:0]   h_len, l_len, n_total, phase_cnt, tally;
  logic           idle_level;

  logic [3:0]     opcode;
  logic [W-1:0]   cmd_h, cmd_l, cmd_n;
  logic           cmd_start, cmd_stop, cmd_set_idle;
  logic           start_train, go_high, go_low, rpt_en;
  logic [3:0]     rpt_status;
  logic [W-1:0]   rpt_tally;
  logic           unused_cmd;

  // A programmed length of 0 behaves as a one-cycle phase.
  function automatic logic [W-1:0] min_one(input logic [W-1:0] v);
    return (v == '0) ? W'(1) : v;
  endfunction

  assign opcode       = cmd_in[63:60];
  assign cmd_h        = cmd_in[3*W-1:2*W];
  assign cmd_l        = cmd_in[2*W-1:W];
  assign cmd_n        = cmd_in[W-1:0];
  assign cmd_start    = valid && (opcode == OP_START);
  assign cmd_stop     = valid && (opcode == OP_STOP);
  assign cmd_set_idle = valid && (opcode == OP_SET_IDLE);
  assign unused_cmd   = ^cmd_in[59:0];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Commands take priority over the phase timer in the same cycle.
  always_comb begin
    next_state  = state;
    start_train = 1'b0;
    go_high     = 1'b0;
    go_low      = 1'b0;
    rpt_en      = 1'b0;
    rpt_status  = ST_DONE;
    rpt_tally   = tally;
    if (cmd_start) begin
      if (state != S_IDLE) begin
        rpt_en     = 1'b1;
        rpt_status = ST_RESTARTED;
      end else if (cmd_n == '0) begin
        rpt_en     = 1'b1;
        rpt_tally  = '0;
      end
      if (cmd_n != '0) begin
        next_state  = S_HIGH;
        start_train = 1'b1;
      end else begin
        next_state  = S_IDLE;
      end
    end else if (cmd_stop && (state != S_IDLE)) begin
      next_state = S_IDLE;
      rpt_en     = 1'b1;
      rpt_status = ST_ABORTED;
    end else begin
      case (state)
        S_HIGH: if (phase_cnt == '0) begin
          next_state = S_LOW;
          go_low     = 1'b1;
        end
        S_LOW: if (phase_cnt == '0) begin
          if (tally < n_total) begin
            next_state = S_HIGH;
            go_high    = 1'b1;
          end else begin
            next_state = S_IDLE;
            rpt_en     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (state != S_IDLE);
    pulse_out = idle_level ^ (state == S_HIGH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tally      <= '0;
      idle_level <= 1'b0;
      write      <= 1'b0;
      report_out <= '0;
    end else begin
      write <= rpt_en;
      if (rpt_en)
        report_out <= {counter, rpt_status, {(60-W){1'b0}}, rpt_tally};
      if (start_train)
        tally <= W'(1);
      else if (cmd_start)
        tally <= '0;
      else if (go_high)
        tally <= tally + W'(1);
      if (cmd_set_idle && (state == S_IDLE))
        idle_level <= cmd_in[0];
    end
  end

  // Phase timer counts down to zero; only meaningful while a train is active.
  always_ff @(posedge clk) begin
    if (start_train) begin
      h_len     <= min_one(cmd_h);
      l_len     <= min_one(cmd_l);
      n_total   <= cmd_n;
      phase_cnt <= min_one(cmd_h) - W'(1);
    end else if (go_low) begin
      phase_cnt <= l_len - W'(1);
    end else if (go_high) begin
      phase_cnt <= h_len - W'(1);
    end else if (state != S_IDLE) begin
      phase_cnt <= phase_cnt - W'(1);
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Bench for pulse_train_generator: expected reports queued at command time and
// matched on each write; pulse/busy waveforms checked cycle by cycle.
module tb_pulse_train_generator;

  localparam logic [63:0] BASE = 64'h1234_0000_0000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  cmd_in;
  logic         valid;
  logic [63:0]  counter;
  logic         pulse_out, busy, write;
  logic [127:0] report_out;

  longint       cyc = 0;
  int           err_cnt = 0;
  int           chk_cnt = 0;
  int           edges = 0;
  logic         prev_pulse = 1'b0;
  logic [127:0] sb[$];

  pulse_train_generator #(.DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .cmd_in(cmd_in), .valid(valid), .counter(counter),
    .pulse_out(pulse_out), .busy(busy), .write(write), .report_out(report_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign counter = BASE + 64'(cyc);

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_start(input int h, input int l, input int n);
    logic [15:0] hh, ll, nn;
    hh = 16'(h); ll = 16'(l); nn = 16'(n);
    return {4'd1, 12'd0, hh, ll, nn};
  endfunction

  function automatic logic [127:0] mk_rpt(input longint at_edge, input int status, input int tally);
    logic [3:0]  st;
    logic [15:0] ta;
    st = 4'(status); ta = 16'(tally);
    return {BASE + 64'(at_edge), st, 44'd0, ta};
  endfunction

  task automatic drive(input logic [63:0] c, output longint t);
    t = cyc;
    cmd_in = c;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    cmd_in = '0;
  endtask

  always @(negedge clk) begin
    if (write === 1'b1) begin
      if (sb.size() == 0) check("unexpected_write", 1, 0);
      else check("report", report_out, sb.pop_front());
    end
  end

  always @(negedge clk) begin
    if (pulse_out === 1'b1 && prev_pulse === 1'b0) edges <= edges + 1;
    prev_pulse <= pulse_out;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t, t2;
    int e0;
    reset = 1'b1; valid = 1'b0; cmd_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_pulse", pulse_out, 0);
    check("rst_busy", busy, 0);
    check("rst_write", write, 0);
    check("rst_report", report_out, 0);
    repeat (2) @(negedge clk);

    // Basic train H=3 L=2 N=4
    drive(mk_start(3, 2, 4), t);
    sb.push_back(mk_rpt(t + 20, 1, 4));
    for (int j = 0; j < 22; j++) begin
      check("t1_pulse", pulse_out, (j < 20 && (j % 5) < 3));
      check("t1_busy", busy, (j < 20));
      @(negedge clk);
    end

    // Zero count, ignored opcode, STOP in idle
    drive(mk_start(3, 3, 0), t);
    sb.push_back(mk_rpt(t, 1, 0));
    for (int j = 0; j < 4; j++) begin
      check("t2_pulse", pulse_out, 0);
      check("t2_busy", busy, 0);
      @(negedge clk);
    end
    drive({4'd7, 60'hFFF_FFFF_FFFF_FFFF}, t);
    check("ign_busy", busy, 0);
    drive({4'd2, 60'd0}, t);
    check("stop_idle_busy", busy, 0);
    repeat (3) @(negedge clk);

    // Abort during the 3rd HIGH
    drive(mk_start(4, 4, 10), t);
    repeat (16) @(negedge clk);
    check("t3_pre_pulse", pulse_out, 1);
    sb.push_back(mk_rpt(cyc, 2, 3));
    drive({4'd2, 60'd0}, t2);
    check("t3_pulse", pulse_out, 0);
    check("t3_busy", busy, 0);
    repeat (5) @(negedge clk);

    // Restart during the 2nd LOW
    drive(mk_start(3, 3, 5), t);
    repeat (10) @(negedge clk);
    check("t4_pre_pulse", pulse_out, 0);
    sb.push_back(mk_rpt(cyc, 3, 2));
    sb.push_back(mk_rpt(cyc + 8, 1, 2));
    drive(mk_start(2, 2, 2), t2);
    check("t4_pulse", pulse_out, 1);
    check("t4_busy", busy, 1);
    repeat (12) @(negedge clk);

    // Idle polarity 1 with zero-length phases
    drive({4'd3, 59'd0, 1'b1}, t);
    check("t5_idle", pulse_out, 1);
    check("t5_idle_busy", busy, 0);
    drive(mk_start(0, 0, 2), t);
    sb.push_back(mk_rpt(t + 4, 1, 2));
    for (int j = 0; j < 5; j++) begin
      check("t5_pulse", pulse_out, (j % 2 == 1) || (j == 4));
      check("t5_busy", busy, (j < 4));
      @(negedge clk);
    end
    drive({4'd3, 59'd0, 1'b0}, t);
    check("t5_idle0", pulse_out, 0);
    repeat (2) @(negedge clk);

    // Reset in the 2nd HIGH, with a START presented in the same cycle
    drive(mk_start(3, 3, 5), t);
    repeat (6) @(negedge clk);
    check("t6_pre_pulse", pulse_out, 1);
    reset = 1'b1;
    cmd_in = mk_start(3, 3, 5);
    valid = 1'b1;
    @(negedge clk);
    reset = 1'b0; valid = 1'b0; cmd_in = '0;
    check("t6_pulse", pulse_out, 0);
    check("t6_busy", busy, 0);
    check("t6_write", write, 0);
    check("t6_report", report_out, 0);
    repeat (10) @(negedge clk);

    // Loopback edge count for N=100
    e0 = edges;
    drive(mk_start(1, 1, 100), t);
    sb.push_back(mk_rpt(t + 200, 1, 100));
    repeat (205) @(negedge clk);
    check("loop_edges", 128'(edges - e0), 100);
    check("loop_busy", busy, 0);

    repeat (3) @(negedge clk);
    check("sb_empty", 128'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
